or4_req_arbiter: RTL and testbench
==================================

Name: or4_req_arbiter

Overview:
- Round-robin arbiter sharing one downstream resource among 4 requesters.
- The any-request summary is the 4-input OR of the request lines.
- Grants are registered and one-hot; the owner holds the grant until it drops its request.
- Sits in front of any single-ported resource in the same fabric.

Parameters:
- MAX_HOLD, 16: maximum consecutive grant cycles while others wait (used only with the optional feature); legal 2..2^CNT_W-1.
- CNT_W, 5: hold-counter width.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- req  in  4  request per requester, level; bit i = requester i.
- gnt  out  4  registered one-hot grant; 0 when no owner.
- gnt_id  out  2  binary index of the current owner; holds last value when gnt_valid=0.
- gnt_valid  out  1  registered; 1 iff gnt != 0.
- any_req  out  1  combinational: req[0]|req[1]|req[2]|req[3].
- timeout  out  1  registered 1-cycle pulse on forced rotation; tied 0 without the optional feature.

Behaviour:
- Reset (async assert, sync release) values:
  - gnt=0, gnt_valid=0, gnt_id=0, timeout=0.
  - state=IDLE, last_id=3, so requester 0 has top priority first.
  - hold_cnt=0.
- Priority is rotating. Search order is last_id+1, last_id+2, last_id+3, last_id (mod 4). The first set req bit wins.
- State IDLE:
  - req==0: stay IDLE; outputs unchanged.
  - any req set: at the next edge, gnt=onehot(winner), gnt_id=winner, gnt_valid=1, last_id=winner, state=GRANT.
  - Latency from req rising to gnt = 1 cycle.
- State GRANT:
  - req[gnt_id]==1: grant held, gnt unchanged, hold_cnt increments (saturates at all-ones).
  - req[gnt_id]==0 and other requests pending: at the next edge the grant moves directly to the next winner. No idle bubble. hold_cnt=0 and last_id=new winner.
  - req[gnt_id]==0 and no other request: at the next edge gnt=0, gnt_valid=0, state=IDLE, hold_cnt=0. last_id is kept.
- Simultaneous events:
  - Owner dropping while others rise in the same cycle: the new winner is selected from the req values sampled at that edge.
  - Owner re-asserting in the same cycle it drops: not possible, since a level is sampled once per edge.
- Requests from non-owners never alter gnt while the owner holds.
- gnt is always one-hot or zero. gnt_valid == |gnt. gnt_id matches gnt whenever gnt_valid=1.
- Mid-operation reset clears the grant immediately, asynchronously. After release, arbitration restarts from last_id=3.
- any_req has no clock dependency. It is valid during reset.

Optional Feature:
- Macro: OR4_REQ_ARBITER_TIMEOUT_EN.
- Defined:
  - In GRANT, hold_cnt counts cycles the owner has held with req[gnt_id]==1.
  - When hold_cnt==MAX_HOLD-1 and any other req bit is set, the next edge forces a handoff to the next round-robin winner, excluding the current owner.
  - That edge also sets last_id=new winner, hold_cnt=0, and timeout=1 for exactly one cycle.
  - With no other request pending, hold_cnt saturates and no rotation occurs.
- Undefined:
  - Hold counter is not instantiated; timeout is tied to 0.
  - Grants are held indefinitely while the owner requests.

Test Plan:
- Reset check: assert rst with req=4'b1111 -> gnt=0, gnt_valid=0, timeout=0, any_req=1. Release rst -> next edge gnt=4'b0001, gnt_id=0.
- Fairness: req=4'b1111; each owner drops for 1 cycle after grant, then re-asserts -> grant order 0,1,2,3,0 with no idle cycles between grants.
- Hold: req=4'b0110, owner 1 held 10 cycles while req[2]=1 -> gnt=4'b0010 throughout. req[1] drops -> next edge gnt=4'b0100.
- Idle return: single req=4'b1000 for 3 cycles, then 0 -> gnt=4'b1000 from cycle 1 to cycle 3. gnt=0 and gnt_valid=0 one edge after the drop. Next req=4'b0001 -> gnt=4'b0001.
- Async reset mid-grant: rst pulsed between edges while gnt=4'b0100 -> gnt=0 immediately, without waiting for clk. After release with req=4'b0100 -> gnt_id=2 one edge later.
- Timeout (OR4_REQ_ARBITER_TIMEOUT_EN, MAX_HOLD=4): req=4'b0011 held constant -> gnt=0001 for 4 cycles, then gnt=0010 with timeout=1 for 1 cycle. After 4 more cycles gnt=0001 with timeout=1. Without the macro -> gnt stays 0001 and timeout stays 0.

Source files
------------

// File: rtl/or4_req_arbiter.sv
// Round-robin arbiter granting one of four requesters a shared resource.
// Optional forced rotation after MAX_HOLD cycles: define OR4_REQ_ARBITER_TIMEOUT_EN.
module or4_req_arbiter #(
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic [1:0] gnt_id,
    output logic       gnt_valid,
    output logic       any_req,
    output logic       timeout
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t     r_state, w_state_nxt;
    logic [3:0] r_gnt, w_gnt_nxt;
    logic [1:0] r_gnt_id, w_gnt_id_nxt;
    logic [1:0] r_last_id, w_last_id_nxt;
    logic [3:0] w_others;
    logic [2:0] w_pick;
    logic       w_owner_req;
    logic       w_hand;

    if (MAX_HOLD < 2 || MAX_HOLD > (2 ** CNT_W) - 1) begin : g_bad_max_hold
        $error("or4_req_arbiter: MAX_HOLD must lie in 2..2**CNT_W-1");
    end

    // Returns {found, index}: first set bit scanning last+1, last+2, last+3, last.
    function automatic logic [2:0] rrPick(input logic [3:0] r, input logic [1:0] last);
        logic [1:0] idx;
        rrPick = 3'b000;
        for (int k = 1; k <= 4; k++) begin
            idx = last + 2'(k);
            if (!rrPick[2] && r[idx]) rrPick = {1'b1, idx};
        end
    endfunction

    assign any_req     = |req;
    assign w_owner_req = |(req & r_gnt);
    assign w_others    = req & ~r_gnt;
    assign w_pick      = rrPick(w_others, r_last_id);

`ifdef OR4_REQ_ARBITER_TIMEOUT_EN
    logic [CNT_W-1:0] r_hold_cnt, w_hold_nxt;
    logic             r_timeout;
    logic             w_force;

    assign w_force = (r_state == GRANT) && w_owner_req && w_pick[2]
                     && (r_hold_cnt == CNT_W'(MAX_HOLD - 1));

    always_comb begin
        w_hold_nxt = '0;
        if (r_state == GRANT && w_owner_req && !w_force) begin
            w_hold_nxt = (r_hold_cnt != '1) ? r_hold_cnt + 1'b1 : r_hold_cnt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hold_cnt <= '0;
            r_timeout  <= 1'b0;
        end else begin
            r_hold_cnt <= w_hold_nxt;
            r_timeout  <= w_force;
        end
    end

    assign timeout = r_timeout;
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        w_state_nxt   = r_state;
        w_gnt_nxt     = r_gnt;
        w_gnt_id_nxt  = r_gnt_id;
        w_last_id_nxt = r_last_id;
        w_hand        = 1'b0;
        case (r_state)
            IDLE: begin
                w_hand = w_pick[2];
            end
            GRANT: begin
                if (!w_owner_req) begin
                    if (w_pick[2]) begin
                        w_hand = 1'b1;
                    end else begin
                        w_state_nxt = IDLE;
                        w_gnt_nxt   = '0;
                    end
                end
`ifdef OR4_REQ_ARBITER_TIMEOUT_EN
                else if (w_force) begin
                    w_hand = 1'b1;
                end
`endif
            end
            default: begin
                w_state_nxt = IDLE;
                w_gnt_nxt   = '0;
            end
        endcase
        // Owner is masked out of the search, so a handoff never re-grants it.
        if (w_hand) begin
            w_state_nxt   = GRANT;
            w_gnt_nxt     = 4'(1) << w_pick[1:0];
            w_gnt_id_nxt  = w_pick[1:0];
            w_last_id_nxt = w_pick[1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_gnt     <= '0;
            r_gnt_id  <= 2'd0;
            r_last_id <= 2'd3;
        end else begin
            r_state   <= w_state_nxt;
            r_gnt     <= w_gnt_nxt;
            r_gnt_id  <= w_gnt_id_nxt;
            r_last_id <= w_last_id_nxt;
        end
    end

    assign gnt       = r_gnt;
    assign gnt_id    = r_gnt_id;
    assign gnt_valid = (r_state == GRANT);

endmodule

// File: tb/tb_or4_req_arbiter.sv
// Bench for or4_req_arbiter: directed scenarios then random request traffic,
// all checked against a behavioural round-robin model.
module tb_or4_req_arbiter;

    localparam int MAXH = 4;
    localparam int CNTW = 5;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       gnt_valid;
    logic       any_req;
    logic       timeout;

    int nTotal  = 0;
    int nPassed = 0;

    // Reference state: -1 means no owner
    int mOwner;
    int mLast;
    int mId;
    int mHold;
    bit mTimeout;

    or4_req_arbiter #(.MAX_HOLD(MAXH), .CNT_W(CNTW)) dut (
        .clk(clk),
        .rst(rst),
        .req(req),
        .gnt(gnt),
        .gnt_id(gnt_id),
        .gnt_valid(gnt_valid),
        .any_req(any_req),
        .timeout(timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, got running required finished");
        $fatal(1, "[TB] watchdog");
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        nTotal++;
        assert (obs === exp) nPassed++;
        else $error("[TB] FAIL %s: got %0h required %0h at %0t", tag, obs, exp, $time);
    endtask

    task automatic modelReset();
        mOwner   = -1;
        mLast    = 3;
        mId      = 0;
        mHold    = 0;
        mTimeout = 0;
    endtask

    task automatic modelStep(input logic [3:0] r);
        int  w;
        int  c;
        bit  rotate;
        rotate   = 0;
        mTimeout = 0;
        if (mOwner >= 0 && r[mOwner]) begin
`ifdef OR4_REQ_ARBITER_TIMEOUT_EN
            if (mHold == MAXH - 1 && (r & ~(4'b0001 << mOwner)) != 4'b0000) rotate = 1;
`endif
            if (!rotate) begin
                if (mHold < (1 << CNTW) - 1) mHold++;
                return;
            end
        end
        w = -1;
        for (int k = 1; k <= 4; k++) begin
            c = (mLast + k) % 4;
            if (w < 0 && r[c] && c != mOwner) w = c;
        end
        mHold = 0;
        if (w >= 0) begin
            mOwner   = w;
            mLast    = w;
            mId      = w;
            mTimeout = rotate;
        end else begin
            mOwner = -1;
        end
    endtask

    task automatic checkOutput(input string tag);
        logic [3:0] expGnt;
        expGnt = (mOwner >= 0) ? (4'b0001 << mOwner) : 4'b0000;
        chk({tag, ".gnt"}, {4'b0, gnt}, {4'b0, expGnt});
        chk({tag, ".gnt_valid"}, {7'b0, gnt_valid}, {7'b0, (mOwner >= 0)});
        chk({tag, ".gnt_id"}, {6'b0, gnt_id}, 8'(mId));
        chk({tag, ".timeout"}, {7'b0, timeout}, {7'b0, mTimeout});
        chk({tag, ".any_req"}, {7'b0, any_req}, {7'b0, |req});
    endtask

    task automatic applyStimulus(input logic [3:0] r, input string tag);
        req = r;
        @(posedge clk);
        modelStep(r);
        #1;
        checkOutput(tag);
    endtask

    initial begin
        logic [3:0] r;
        $display("[TB] start");
        modelReset();

        rst = 1'b1;
        req = 4'b1111;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset");
        #3;
        rst = 1'b0;

        applyStimulus(4'b1111, "first");
        chk("first.gnt_const", {4'b0, gnt}, 8'h01);

        // Fairness: each owner drops for one cycle after it is granted
        applyStimulus(4'b1110, "fair1");
        chk("fair1.gnt_const", {4'b0, gnt}, 8'h02);
        applyStimulus(4'b1101, "fair2");
        applyStimulus(4'b1011, "fair3");
        applyStimulus(4'b0111, "fair0");
        chk("fair0.gnt_const", {4'b0, gnt}, 8'h01);

        // Hold while a non-owner waits
        applyStimulus(4'b0110, "hold_start");
        for (int i = 0; i < 10; i++) applyStimulus(4'b0110, "hold");
        applyStimulus(4'b0100, "hold_drop");

        // Single requester, then return to idle
        for (int i = 0; i < 3; i++) applyStimulus(4'b1000, "single");
        applyStimulus(4'b0000, "idle");
        chk("idle.gnt_valid_const", {7'b0, gnt_valid}, 8'h00);
        applyStimulus(4'b0000, "idle2");
        applyStimulus(4'b0001, "after_idle");

        // Asynchronous reset between edges while requester 2 owns
        applyStimulus(4'b0100, "pre_async");
        applyStimulus(4'b0100, "pre_async2");
        #3;
        rst = 1'b1;
        #1;
        modelReset();
        checkOutput("async_rst");
        #2;
        rst = 1'b0;
        applyStimulus(4'b0100, "post_async");
        chk("post_async.id_const", {6'b0, gnt_id}, 8'h02);

        // Constant pair of requests exercises forced rotation when enabled
        applyStimulus(4'b0000, "to_idle");
        for (int i = 0; i < 12; i++) applyStimulus(4'b0011, "pair");

        // Random traffic with sticky request lines
        r = 4'b0000;
        for (int i = 0; i < 400; i++) begin
            r = r ^ (4'($urandom) & 4'($urandom) & 4'($urandom));
            applyStimulus(r, "rand");
        end

        $display("[TB] %0d/%0d checks passed", nPassed, nTotal);
        $finish;
    end

endmodule
